// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet TX/RX types, constants and the CRC32 byte step.
// Holds the TX state enum, framing bytes and the reflected CRC32 helper.
package eth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SFD,
        DATA,
        PAD,
        FCS,
        IFG
    } eth_tx_state_t;

    localparam logic [7:0]  ETH_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  ETH_SFD           = 8'hD5;
    localparam logic [31:0] ETH_CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] ETH_CRC_INIT      = 32'hFFFFFFFF;

    // One byte of IEEE 802.3 CRC32, LSB of the byte first.
    function automatic logic [31:0] crc32_byte(
        input logic [31:0] crc,
        input logic [7:0]  data
    );
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ ETH_CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_crc32.sv
// eth_crc32: registered CRC32 accumulator with synchronous init and enable.
// Ports: clk, reset_n, init_i (load CRC init), en_i + data_i (fold byte), crc_o.
module eth_crc32
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        init_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (init_i) begin
            crc_d = ETH_CRC_INIT;
        end else if (en_i) begin
            crc_d = crc32_byte(crc_q, data_i);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_q <= ETH_CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/eth_mac_tx.sv
// eth_mac_tx: byte-wide Ethernet TX MAC: preamble, SFD, client data, zero pad,
// CRC32 FCS and inter-frame gap, all paced by the PHY byte strobe phy_ce.
// Ports: tx_start/tx_count in, tx_busy/tx_done out (arbiter side);
//   tx_addr/tx_adv/tx_last out, tx_data in (client fetch);
//   phy_ce in, phy_txd/phy_txen out (PHY side).
// Optional macro MAC_TX_STATS_EN adds frame_cnt and byte_cnt outputs.
module eth_mac_tx
    import eth_pkg::*;
#(
    parameter int unsigned PREAMBLE_LEN = 7,
    parameter int unsigned MIN_FRAME    = 60,
    parameter int unsigned IFG_BYTES    = 12,
    parameter int unsigned MAX_FRAME    = 1514
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tx_start,
    input  logic [10:0] tx_count,
    output logic        tx_busy,
    output logic [10:0] tx_addr,
    output logic        tx_adv,
    output logic        tx_last,
    input  logic [7:0]  tx_data,
    input  logic        phy_ce,
    output logic [7:0]  phy_txd,
    output logic        phy_txen,
    output logic        tx_done
`ifdef MAC_TX_STATS_EN
    ,
    output logic [31:0] frame_cnt,
    output logic [31:0] byte_cnt
`endif
);

    eth_tx_state_t state_q, state_d;
    logic [10:0]   cnt_q, cnt_d;
    logic [10:0]   count_q, count_d;
    logic [7:0]    txd_q, txd_d;
    logic          txen_q, txen_d;
    logic          busy_q, busy_d;
    logic          adv_q, adv_d;
    logic          last_q, last_d;
    logic [10:0]   addr_q, addr_d;
    logic          done_q, done_d;

    logic          crc_init;
    logic          crc_en;
    logic [7:0]    crc_data;
    logic [31:0]   crc;
    logic          count_ok;

    assign count_ok = (tx_count != 11'd0)
                   && (tx_count <= 11'(MAX_FRAME));

    eth_crc32 u_crc (
        .clk     (clk),
        .reset_n (reset_n),
        .init_i  (crc_init),
        .en_i    (crc_en),
        .data_i  (crc_data),
        .crc_o   (crc)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        count_d  = count_q;
        txd_d    = txd_q;
        txen_d   = txen_q;
        busy_d   = busy_q;
        adv_d    = 1'b0;
        last_d   = 1'b0;
        addr_d   = addr_q;
        done_d   = 1'b0;
        crc_init = 1'b0;
        crc_en   = 1'b0;
        crc_data = tx_data;

        unique case (state_q)
            IDLE: begin
                // busy trails tx_done by one cycle
                if (done_q) begin
                    busy_d = 1'b0;
                end
                if (tx_start && count_ok) begin
                    state_d = PRE;
                    count_d = tx_count;
                    cnt_d   = 11'd0;
                    busy_d  = 1'b1;
                end
            end
            PRE: begin
                if (phy_ce) begin
                    txd_d  = ETH_PREAMBLE_BYTE;
                    txen_d = 1'b1;
                    if (cnt_q == 11'(PREAMBLE_LEN - 1)) begin
                        state_d = SFD;
                        cnt_d   = 11'd0;
                    end else begin
                        cnt_d = cnt_q + 11'd1;
                    end
                end
            end
            SFD: begin
                if (phy_ce) begin
                    txd_d    = ETH_SFD;
                    adv_d    = 1'b1;
                    addr_d   = 11'd0;
                    last_d   = (count_q == 11'd1);
                    crc_init = 1'b1;
                    state_d  = DATA;
                    cnt_d    = 11'd0;
                end
            end
            DATA: begin
                if (phy_ce) begin
                    txd_d  = tx_data;
                    crc_en = 1'b1;
                    if (cnt_q + 11'd1 < count_q) begin
                        // prefetch the next byte for the following strobe
                        adv_d  = 1'b1;
                        addr_d = cnt_q + 11'd1;
                        last_d = (cnt_q + 11'd2 == count_q);
                        cnt_d  = cnt_q + 11'd1;
                    end else if (count_q < 11'(MIN_FRAME)) begin
                        state_d = PAD;
                        cnt_d   = cnt_q + 11'd1;
                    end else begin
                        state_d = FCS;
                        cnt_d   = 11'd0;
                    end
                end
            end
            PAD: begin
                if (phy_ce) begin
                    txd_d    = 8'h00;
                    crc_data = 8'h00;
                    crc_en   = 1'b1;
                    if (cnt_q == 11'(MIN_FRAME - 1)) begin
                        state_d = FCS;
                        cnt_d   = 11'd0;
                    end else begin
                        cnt_d = cnt_q + 11'd1;
                    end
                end
            end
            FCS: begin
                if (phy_ce) begin
                    txd_d = ~crc[{cnt_q[1:0], 3'b000} +: 8];
                    if (cnt_q == 11'd3) begin
                        state_d = IFG;
                        cnt_d   = 11'd0;
                    end else begin
                        cnt_d = cnt_q + 11'd1;
                    end
                end
            end
            IFG: begin
                if (phy_ce) begin
                    txd_d  = 8'h00;
                    txen_d = 1'b0;
                    if (cnt_q == 11'(IFG_BYTES - 1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                        cnt_d   = 11'd0;
                    end else begin
                        cnt_d = cnt_q + 11'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 11'd0;
            count_q <= 11'd0;
            txd_q   <= 8'h00;
            txen_q  <= 1'b0;
            busy_q  <= 1'b0;
            adv_q   <= 1'b0;
            last_q  <= 1'b0;
            addr_q  <= 11'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            txd_q   <= txd_d;
            txen_q  <= txen_d;
            busy_q  <= busy_d;
            adv_q   <= adv_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
        end
    end

    assign tx_busy  = busy_q;
    assign tx_addr  = addr_q;
    assign tx_adv   = adv_q;
    assign tx_last  = last_q;
    assign phy_txd  = txd_q;
    assign phy_txen = txen_q;
    assign tx_done  = done_q;

`ifdef MAC_TX_STATS_EN
    logic [31:0] frame_cnt_q;
    logic [31:0] byte_cnt_q;
    logic [10:0] flen;

    // wire bytes DA..FCS: padded length plus four FCS bytes
    assign flen = (count_q < 11'(MIN_FRAME)) ? 11'(MIN_FRAME) : count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= 32'd0;
            byte_cnt_q  <= 32'd0;
        end else if (done_q) begin
            frame_cnt_q <= frame_cnt_q + 32'd1;
            byte_cnt_q  <= byte_cnt_q + 32'(flen) + 32'd4;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign byte_cnt  = byte_cnt_q;
`endif

endmodule

// File: tb/tb_eth_mac_tx.sv
// tb_eth_mac_tx: directed self-checking bench for eth_mac_tx.
// Drives a combinational client memory and a PHY strobe, checks wire bytes.
module tb_eth_mac_tx;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        phy_ce = 1'b1;
    logic        stall = 1'b0;

    logic        tx_start = 1'b0;
    logic [10:0] tx_count = 11'd0;
    logic        tx_busy, tx_adv, tx_last, phy_txen, tx_done;
    logic [10:0] tx_addr;
    logic [7:0]  tx_data, phy_txd;

    logic        tx_start0 = 1'b0;
    logic [10:0] tx_count0 = 11'd0;
    logic        tx_busy0, tx_adv0, tx_last0, phy_txen0, tx_done0;
    logic [10:0] tx_addr0;
    logic [7:0]  tx_data0, phy_txd0;

`ifdef MAC_TX_STATS_EN
    logic [31:0] frame_cnt, byte_cnt, frame_cnt0, byte_cnt0;
`endif

    logic [7:0]  mem [0:2047];
    assign tx_data  = mem[tx_addr];
    assign tx_data0 = mem[tx_addr0];

    always #5 clk = ~clk;

    eth_mac_tx dut (
        .clk(clk), .reset_n(reset_n),
        .tx_start(tx_start), .tx_count(tx_count), .tx_busy(tx_busy),
        .tx_addr(tx_addr), .tx_adv(tx_adv), .tx_last(tx_last),
        .tx_data(tx_data), .phy_ce(phy_ce), .phy_txd(phy_txd),
        .phy_txen(phy_txen), .tx_done(tx_done)
`ifdef MAC_TX_STATS_EN
        , .frame_cnt(frame_cnt), .byte_cnt(byte_cnt)
`endif
    );

    eth_mac_tx #(.MIN_FRAME(0)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .tx_start(tx_start0), .tx_count(tx_count0), .tx_busy(tx_busy0),
        .tx_addr(tx_addr0), .tx_adv(tx_adv0), .tx_last(tx_last0),
        .tx_data(tx_data0), .phy_ce(phy_ce), .phy_txd(phy_txd0),
        .phy_txen(phy_txen0), .tx_done(tx_done0)
`ifdef MAC_TX_STATS_EN
        , .frame_cnt(frame_cnt0), .byte_cnt(byte_cnt0)
`endif
    );

    int nvec = 0;
    int nerr = 0;

    logic [7:0]  cap[$], cap0[$], exp_q[$], ref_q[$];
    int          adv_n, adv0_n, last_n, last0_n, adv_bad, en0_cyc, busy_hi, en_hi;
    logic [10:0] last_addr, last0_addr;
    int          ce_ph = 0;

    // Monitor: phy_ce here is the value sampled at the preceding posedge.
    always @(negedge clk) begin
        if (phy_ce && phy_txen)  cap.push_back(phy_txd);
        if (phy_ce && phy_txen0) cap0.push_back(phy_txd0);
        if (tx_adv)  adv_n++;
        if (tx_adv0) adv0_n++;
        if ((tx_adv || tx_last) && !phy_ce) adv_bad++;
        if (tx_last)  begin last_n++;  last_addr  = tx_addr;  end
        if (tx_last0) begin last0_n++; last0_addr = tx_addr0; end
        if (phy_txen0) en0_cyc++;
        if (tx_busy)   busy_hi++;
        if (phy_txen)  en_hi++;
        ce_ph  = (ce_ph + 1) % 4;
        phy_ce = stall ? (ce_ph == 0) : 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clr();
        cap.delete(); cap0.delete();
        adv_n = 0; adv0_n = 0; last_n = 0; last0_n = 0; adv_bad = 0;
        en0_cyc = 0; busy_hi = 0; en_hi = 0;
        last_addr = '0; last0_addr = '0;
    endtask

    task automatic start(input bit sel, input logic [10:0] c);
        @(negedge clk); #2;
        if (sel) begin tx_count0 = c; tx_start0 = 1'b1; end
        else     begin tx_count  = c; tx_start  = 1'b1; end
        @(negedge clk); #2;
        tx_start = 1'b0; tx_start0 = 1'b0;
    endtask

    task automatic wait_done(input string tag, input bit sel, input int budget);
        int n;
        n = 0;
        while (((sel ? tx_done0 : tx_done) !== 1'b1) && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk(tag, 32'(n < budget), 32'd1);
        @(negedge clk); #1;
    endtask

    function automatic logic [31:0] sw_crc(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        repeat (8) r = (r >> 1) ^ (r[0] ? 32'hEDB88320 : 32'h0);
        return r;
    endfunction

    task automatic build(input int c, input int minf);
        logic [31:0] crc;
        logic [7:0]  b;
        int          n;
        exp_q.delete();
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        crc = 32'hFFFFFFFF;
        n = (c < minf) ? minf : c;
        for (int i = 0; i < n; i++) begin
            b = (i < c) ? mem[i] : 8'h00;
            exp_q.push_back(b);
            crc = sw_crc(crc, b);
        end
        crc = ~crc;
        for (int i = 0; i < 4; i++) exp_q.push_back(crc[8*i +: 8]);
    endtask

    task automatic cmp_stream(input string tag, input bit sel);
        int n, nbad;
        n = sel ? cap0.size() : cap.size();
        chk({tag, " len"}, 32'(n), 32'(exp_q.size()));
        nbad = 0;
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            if ((sel ? cap0[i] : cap[i]) !== exp_q[i]) nbad++;
        end
        chk({tag, " bytes"}, 32'(nbad), 32'd0);
    endtask

    initial begin
        int idle;
        int n;
        for (int i = 0; i < 2048; i++) mem[i] = 8'(i * 7 + 3);
        clr();

        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst txen", 32'(phy_txen), 32'd0);
        chk("rst txd",  32'(phy_txd),  32'd0);
        chk("rst busy", 32'(tx_busy),  32'd0);
        chk("rst adv",  32'(tx_adv),   32'd0);
        chk("rst last", 32'(tx_last),  32'd0);
        chk("rst addr", 32'(tx_addr),  32'd0);
        chk("rst done", 32'(tx_done),  32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // smoke: "123456789", no padding
        for (int i = 0; i < 9; i++) mem[i] = 8'h31 + 8'(i);
        clr();
        start(1'b1, 11'd9);
        wait_done("smoke done", 1'b1, 200);
        exp_q.delete();
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 9; i++) exp_q.push_back(8'h31 + 8'(i));
        exp_q.push_back(8'h26); exp_q.push_back(8'h39);
        exp_q.push_back(8'hF4); exp_q.push_back(8'hCB);
        cmp_stream("smoke", 1'b1);
        chk("smoke txen cycles", 32'(en0_cyc), 32'd21);
        chk("smoke last count", 32'(last0_n), 32'd1);
        chk("smoke last addr", 32'(last0_addr), 32'd8);
        chk("smoke adv count", 32'(adv0_n), 32'd9);
`ifdef MAC_TX_STATS_EN
        chk("smoke frame_cnt", frame_cnt0, 32'd1);
        chk("smoke byte_cnt", byte_cnt0, 32'd13);
`endif
        for (int i = 0; i < 2048; i++) mem[i] = 8'(i * 7 + 3);

        // padding: 46 bytes -> 60 on the wire
        clr();
        start(1'b0, 11'd46);
        wait_done("pad done", 1'b0, 300);
        build(46, 60);
        cmp_stream("pad", 1'b0);
        chk("pad adv count", 32'(adv_n), 32'd46);
        chk("pad last count", 32'(last_n), 32'd1);
        chk("pad last addr", 32'(last_addr), 32'd45);

        // full-rate 60-byte reference, then the same frame with a stalled strobe
        clr();
        start(1'b0, 11'd60);
        wait_done("ref done", 1'b0, 300);
        build(60, 60);
        cmp_stream("ref60", 1'b0);
        ref_q = cap;
        stall = 1'b1;
        clr();
        start(1'b0, 11'd60);
        wait_done("stall done", 1'b0, 1500);
        exp_q = ref_q;
        cmp_stream("stall", 1'b0);
        chk("stall adv off-strobe", 32'(adv_bad), 32'd0);
        chk("stall adv count", 32'(adv_n), 32'd60);
        stall = 1'b0;
        repeat (4) @(negedge clk);

        // back-to-back with an ignored start inside the IFG
        clr();
        start(1'b0, 11'd60);
        n = 0;
        while (phy_txen !== 1'b1 && n < 200) begin @(negedge clk); #1; n++; end
        while (phy_txen !== 1'b0 && n < 200) begin @(negedge clk); #1; n++; end
        chk("b2b frame end", 32'(n < 200), 32'd1);
        idle = 1;
        while (tx_done !== 1'b1 && idle < 40) begin
            if (idle == 3) begin tx_count = 11'd60; tx_start = 1'b1; end
            else tx_start = 1'b0;
            @(negedge clk); #1;
            if (!phy_txen) idle++;
        end
        tx_start = 1'b0;
        chk("b2b ifg idle", 32'(idle), 32'd12);
        chk("b2b busy at done", 32'(tx_busy), 32'd1);
        @(negedge clk); #1;
        chk("b2b busy fell", 32'(tx_busy), 32'd0);
        chk("b2b txen idle", 32'(phy_txen), 32'd0);
        @(negedge clk); #1;
        tx_count = 11'd60; tx_start = 1'b1;
        @(negedge clk); #1;
        tx_start = 1'b0;
        wait_done("b2b second done", 1'b0, 300);
        chk("b2b total bytes", 32'(cap.size()), 32'd144);

        // invalid counts
        clr();
        start(1'b0, 11'd0);
        repeat (20) @(negedge clk);
        start(1'b0, 11'd1515);
        repeat (20) @(negedge clk);
        #1;
        chk("bad count busy", 32'(busy_hi), 32'd0);
        chk("bad count txen", 32'(en_hi), 32'd0);

        // reset in the middle of the data phase
        clr();
        start(1'b0, 11'd60);
        n = 0;
        while (cap.size() < 28 && n < 300) begin @(negedge clk); #1; n++; end
        chk("mid reached data 20", 32'(n < 300), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid reset txen", 32'(phy_txen), 32'd0);
        chk("mid reset busy", 32'(tx_busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        clr();
        start(1'b0, 11'd60);
        wait_done("post reset done", 1'b0, 300);
        build(60, 60);
        cmp_stream("post reset", 1'b0);
`ifdef MAC_TX_STATS_EN
        chk("stats frame_cnt", frame_cnt, 32'd1);
        chk("stats byte_cnt", byte_cnt, 32'd64);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/eth_mac_tx.md
Name: eth_mac_tx

Overview:
- Byte-wide Ethernet transmit MAC directly downstream of the UDP/ARP TX machines and the TX arbiter.
- On a start pulse from the arbiter, emits the preamble and SFD, then fetches frame bytes from the granted client over the tx_addr/tx_adv/tx_last/tx_data interface.
- Zero-pads the frame to the minimum length, appends the CRC32 FCS, and enforces the inter-frame gap.
- All progress is gated by a PHY byte strobe, so one clock domain serves several line rates.

Parameters:
- PREAMBLE_LEN, 7: number of 0x55 bytes before the SFD.
- MIN_FRAME, 60: minimum DA..payload length; shorter frames are zero-padded (0 disables padding).
- IFG_BYTES, 12: idle byte times after the FCS.
- MAX_FRAME, 1514: largest accepted tx_count.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- tx_start  in  1  one-cycle pulse from the arbiter at grant
- tx_count  in  11  frame byte count (DA..payload, no FCS); sampled with tx_start
- tx_busy  out  1  high from the cycle after an accepted tx_start until the IFG ends
- tx_addr  out  11  client byte address
- tx_adv  out  1  fetch strobe for tx_addr
- tx_last  out  1  high with the tx_adv of address count-1
- tx_data  in  8  client byte; valid from the cycle after tx_adv and held until the next tx_adv
- phy_ce  in  1  byte strobe; one PHY byte per phy_ce cycle
- phy_txd  out  8  transmit byte
- phy_txen  out  1  transmit enable
- tx_done  out  1  one-cycle pulse on the phy_ce cycle that ends the IFG

Behaviour:
- Reset values (asynchronous, active-low): state=IDLE; phy_txd=0x00, phy_txen=0, tx_busy=0, tx_adv=0, tx_last=0, tx_addr=0, tx_done=0; CRC=0xFFFFFFFF.
- Asserting reset mid-frame drops phy_txen immediately; the frame is truncated, with no FCS.
- All outputs are registered.
- tx_start handling:
  - Honoured only in IDLE.
  - tx_count is latched with it.
  - A count of 0 or a count > MAX_FRAME is ignored: the block stays IDLE and tx_busy stays 0.
  - tx_start in any other state is ignored.
- State machine: IDLE -> PRE -> SFD -> DATA -> PAD -> FCS -> IFG -> IDLE. State changes and the byte counter advance only on phy_ce cycles.
- PRE: PREAMBLE_LEN bytes of 0x55, phy_txen=1.
- SFD: one byte of 0xD5. In the same cycle the block issues tx_adv with tx_addr=0, plus tx_last if count==1. The CRC is reset to 0xFFFFFFFF.
- DATA byte k:
  - phy_txd<=tx_data and the CRC is updated with tx_data.
  - If k+1<count, tx_adv is pulsed with tx_addr=k+1; tx_last is high if k+1==count-1.
  - tx_adv and tx_last are single-cycle pulses and coincide only with phy_ce cycles.
  - After byte count-1: go to PAD if count<MIN_FRAME, else to FCS.
- PAD: 0x00 bytes, included in the CRC, until MIN_FRAME bytes have been sent.
- FCS:
  - The CRC is IEEE 802.3 CRC32: reflected polynomial 0xEDB88320, processed LSB first, one byte per phy_ce.
  - Four bytes are sent: ~CRC[7:0], ~CRC[15:8], ~CRC[23:16], ~CRC[31:24].
- IFG: phy_txen=0 and phy_txd=0 for IFG_BYTES phy_ce cycles. tx_done pulses on the last one, and tx_busy falls in the following cycle.
- Wire length per frame is PREAMBLE_LEN + 1 + max(count, MIN_FRAME) + 4 phy_txen byte times.
- With phy_ce held high, back-to-back frames are spaced exactly IFG_BYTES idle cycles apart.
- phy_ce low holds all registers; tx_data must stay stable while the block is stalled.

Optional Feature:
- Macro: MAC_TX_STATS_EN.
- When defined:
  - Adds output frame_cnt [31:0], incremented on each tx_done and wrapping at 2^32.
  - Adds output byte_cnt [31:0], incremented by max(count, MIN_FRAME)+4 per frame and wrapping.
  - Both counters reset to 0.
- When undefined, neither port nor its logic exists.

Decomposition:
- Package eth_pkg holds:
  - The state enum eth_tx_state_t.
  - The constants ETH_PREAMBLE_BYTE=0x55, ETH_SFD=0xD5, ETH_CRC_POLY=0xEDB88320, ETH_CRC_INIT=0xFFFFFFFF.
  - The function crc32_byte(crc, byte), shared with the RX checker.
- Sub-module eth_crc32 (combinational next-CRC plus a registered accumulator with init/enable) is natural and reusable by RX.

Test Plan:
- Smoke frame: PREAMBLE_LEN=7, MIN_FRAME=0, phy_ce=1, tx_count=9 with client bytes "123456789" -> phy_txd shows 55x7, D5, 31..39, then FCS bytes 26 39 F4 CB; phy_txen stays high for 21 cycles; tx_last is seen exactly once, with tx_addr=8.
- Padding: MIN_FRAME=60, tx_count=46 -> 14 trailing 0x00 bytes before the FCS; the FCS matches a software CRC over the 60-byte buffer; tx_adv fires exactly 46 times.
- Stalled strobe: phy_ce=1 every 4th cycle, tx_count=60 UDP frame -> byte stream identical to the phy_ce=1 run; tx_adv only on phy_ce cycles.
- Back-to-back: a tx_start is issued during the IFG and ignored; a second tx_start on the cycle after tx_busy falls starts a new frame -> exactly 12 idle byte times between frames.
- Invalid counts: tx_count=0 and tx_count=1515 -> no phy_txen, tx_busy stays 0.
- Mid-frame reset: reset_n low at DATA byte 20 -> phy_txen=0 the same cycle; after release a new tx_start sends a complete frame.
